// File: rtl/adder4_sched.sv
// adder4_sched: shares one external 4-bit adder slice between two requesters.
// A round-robin arbiter accepts one operation at a time. The operation is run
// one nibble per cycle with the carry chained through a register. The tagged
// result is then returned over a valid/ready handshake.
module adder4_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_sub,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout,
  output logic                   res_id
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            carry;
  logic            cout_reg;
  logic            id_reg;
  logic            last_grant;
  logic [KW-1:0]   k;

  logic            grant0;
  logic            grant1;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_sub;

  // Round-robin arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && (!req1_valid || last_grant)) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
    req0_ready = (state == IDLE) && !rst && grant0;
    req1_ready = (state == IDLE) && !rst && grant1;
    sel_a   = req1_ready ? req1_a   : req0_a;
    sel_b   = req1_ready ? req1_b   : req0_b;
    sel_sub = req1_ready ? req1_sub : req0_sub;
  end

  // Drive the shared slice only while an operation is running; it idles at zero otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if ((state == RUN) && !rst) begin
      add_a   = a_reg[{k, 2'b00} +: 4];
      add_b   = b_reg[{k, 2'b00} +: 4];
      add_cin = carry;
    end
  end

  // Result outputs come straight from held registers; res_valid is suppressed during reset.
  always_comb begin
    res_valid = (state == DONE) && !rst;
    res_sum   = sum_reg;
    res_cout  = cout_reg;
    res_id    = id_reg;
  end

  // Sequencer: accept, walk the nibbles chaining carry, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      carry      <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            a_reg      <= sel_a;
            b_reg      <= sel_b ^ {W{sel_sub}};
            carry      <= sel_sub;
            k          <= '0;
            id_reg     <= req1_ready;
            last_grant <= req1_ready;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_reg[{k, 2'b00} +: 4] <= add_s;
          carry                    <= add_cout;
          if (k == K_LAST) begin
            cout_reg <= add_cout;
            k        <= '0;
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder4_sched.sv
// Testbench for adder4_sched: directed and randomized operations checked against
// a plain-arithmetic reference of wide add/subtract, nibble carries and arbitration.
module tb_adder4_sched;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req0_sub;
  logic [W-1:0]   req0_a, req0_b;
  logic           req1_valid, req1_ready, req1_sub;
  logic [W-1:0]   req1_a, req1_b;
  logic [3:0]     add_a, add_b, add_s;
  logic           add_cin, add_cout;
  logic           res_valid, res_ready, res_cout, res_id;
  logic [W-1:0]   res_sum;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   obs_sum;
  logic           obs_cout;

  always #5 clk = ~clk;

  adder4_sched #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  // External 4-bit adder slice
  always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cout, sum}: add is a+b; subtract is a-b+2^W so bit W means "no borrow".
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    longint unsigned r;
    if (sub) r = 64'(a) + (64'd1 << W) - 64'(b);
    else     r = 64'(a) + 64'(b);
    return r[W:0];
  endfunction

  // Carry entering nibble k, from the low 4k bits of the operands.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input int k);
    longint unsigned m, al, bl;
    m  = 64'd1 << (4 * k);
    al = 64'(a) % m;
    bl = 64'(b) % m;
    return sub ? (al >= bl) : ((al + bl) >= m);
  endfunction

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
    logic [W-1:0] t;
    t = v >> (4 * k);
    return t[3:0];
  endfunction

  // Serve one operation by the requester expected to win; hold>0 keeps res_ready low that long.
  task automatic serve(input int exp_id, input int hold, input bit refill);
    int           waited;
    logic [W-1:0] ga, gb, bx;
    logic         gs;
    logic [W:0]   exp_r;
    waited = 0;
    while (!(req0_ready || req1_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("grant_seen", req0_ready || req1_ready, 1'b1);
    if (!(req0_ready || req1_ready)) return;
    chk("grant0", req0_ready, exp_id == 0);
    chk("grant1", req1_ready, exp_id == 1);
    if (exp_id == 0) {ga, gb, gs} = {req0_a, req0_b, req0_sub};
    else             {ga, gb, gs} = {req1_a, req1_b, req1_sub};
    exp_r = ref_result(ga, gb, gs);
    bx    = gs ? ~gb : gb;
    @(posedge clk);
    #1;
    res_ready = (hold == 0);
    if (exp_id == 0) begin
      if (refill) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom); end
      else req0_valid = 1'b0;
    end else begin
      if (refill) begin req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom); end
      else req1_valid = 1'b0;
    end
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      chk("run_add_a", add_a, nib(ga, k));
      chk("run_add_b", add_b, nib(bx, k));
      chk("run_add_cin", add_cin, cin_at(ga, gb, gs, k));
      chk("run_res_valid", res_valid, 1'b0);
      chk("run_ready", {req0_ready, req1_ready}, 2'b00);
    end
    @(negedge clk);
    chk("done_valid", res_valid, 1'b1);
    chk("done_sum", res_sum, exp_r[W-1:0]);
    chk("done_cout", res_cout, exp_r[W]);
    chk("done_id", res_id, exp_id == 1);
    chk("done_ready", {req0_ready, req1_ready}, 2'b00);
    chk("done_add_a", add_a, 4'd0);
    obs_sum  = res_sum;
    obs_cout = res_cout;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", res_valid, 1'b1);
        chk("hold_sum", res_sum, exp_r[W-1:0]);
        chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("leave_done", res_valid, 1'b0);
    end
  endtask

  initial begin
    int id;
    int waited;
    rst        = 1'b1;
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
    req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rst_valid", res_valid, 1'b0);
    end
    chk("rst_sum", res_sum, 16'h0000);
    chk("rst_cout", res_cout, 1'b0);
    chk("rst_id", res_id, 1'b0);
    chk("rst_add", {add_a, add_b, add_cin}, 9'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both valid continuously out of reset: grants alternate 0,1,0,1
    serve(0, 0, 1'b1);
    serve(1, 0, 1'b1);
    serve(0, 0, 1'b0);
    serve(1, 0, 1'b0);

    // Directed add with carry chain 0,1,1,1
    req0_a = 16'h1234; req0_b = 16'h0FCD; req0_sub = 1'b0; req0_valid = 1'b1;
    serve(0, 0, 1'b0);
    chk("dir_add_sum", obs_sum, 16'h2201);
    chk("dir_add_cout", obs_cout, 1'b0);

    // Directed subtracts on requester 1
    req1_a = 16'h0005; req1_b = 16'h0007; req1_sub = 1'b1; req1_valid = 1'b1;
    serve(1, 0, 1'b0);
    chk("dir_sub1_sum", obs_sum, 16'hFFFE);
    chk("dir_sub1_cout", obs_cout, 1'b0);
    req1_a = 16'h0007; req1_b = 16'h0005; req1_sub = 1'b1; req1_valid = 1'b1;
    serve(1, 0, 1'b0);
    chk("dir_sub2_sum", obs_sum, 16'h0002);
    chk("dir_sub2_cout", obs_cout, 1'b1);

    // Wraparound
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_sub = 1'b0; req0_valid = 1'b1;
    serve(0, 0, 1'b0);
    chk("dir_wrap_sum", obs_sum, 16'h0000);
    chk("dir_wrap_cout", obs_cout, 1'b1);

    // Result back-pressure for 10 cycles with a requester still waiting
    req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom); req0_valid = 1'b1;
    serve(0, 10, 1'b1);
    serve(0, 0, 1'b0);

    // Randomized single-requester operations
    for (int i = 0; i < 8; i++) begin
      id = $urandom_range(0, 1);
      if (id == 0) begin
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom); req0_valid = 1'b1;
      end else begin
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom); req1_valid = 1'b1;
      end
      serve(id, 0, 1'b0);
    end

    // Reset during the second RUN cycle discards the operation
    req1_a = 16'h0F0F; req1_b = 16'h0101; req1_sub = 1'b1; req1_valid = 1'b1;
    waited = 0;
    while (!req1_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("mid_grant", req1_ready, 1'b1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("mid_rst_add", {add_a, add_b, add_cin}, 9'd0);
    chk("mid_rst_valid", res_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", res_valid, 1'b0);
    chk("after_rst_sum", res_sum, 16'h0000);
    chk("after_rst_cout", res_cout, 1'b0);
    chk("after_rst_id", res_id, 1'b0);
    chk("after_rst_add", {add_a, add_b, add_cin}, 9'd0);
    repeat (8) begin
      @(negedge clk);
      chk("no_result", res_valid, 1'b0);
    end

    // Next request completes normally
    req0_a = 16'hABCD; req0_b = 16'h1111; req0_sub = 1'b0; req0_valid = 1'b1;
    serve(0, 0, 1'b0);
    chk("post_rst_sum", obs_sum, 16'hBCDE);
    chk("post_rst_cout", obs_cout, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder4_sched.md
# adder4_sched

Sequencer and round-robin arbiter that shares one external 4-bit ripple-carry adder slice between two requesters. It performs wide add and subtract operations one nibble per cycle, chaining the carry through an internal register. It sits between two operand producers and the shared adder slice, and returns one tagged result per accepted request over a valid/ready handshake.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_sub  in  1  requester 0 op: 0 = a+b, 1 = a-b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meaning for requester 1.
- add_a, add_b  out  4  nibble operands to the adder slice.
- add_cin  out  1  carry-in to the adder slice.
- add_s  in  4  slice sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  slice carry-out, combinational.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  W  result, mod 2^W.
- res_cout  out  1  final carry-out; for subtract, 1 = no borrow.
- res_id  out  1  requester index that owns the result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - Arbitration is combinational on the valid inputs.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted. The last-grant pointer resets to 1, so req0 wins the first tie.
  - reqN_ready = 1 only for the granted requester, and only in IDLE.
  - On a handshake (valid & ready):
    - Latch a. Latch b, or ~b when sub = 1.
    - Set the carry register to sub (1 for subtract, two's complement).
    - Set nibble index k = 0 and latch id.
    - Update the last-grant pointer and go to RUN.
- RUN, one cycle per nibble:
  - add_a = a[4k+3:4k], add_b = b'[4k+3:4k], add_cin = carry register.
  - At the clock edge: sum[4k+3:4k] <= add_s, carry <= add_cout, k <= k+1.
  - When k = NIBBLES-1 is processed, go to DONE.
- DONE:
  - res_valid = 1. res_sum, res_cout (final carry) and res_id are held stable.
  - On res_valid & res_ready, return to IDLE. A new request can be accepted in that IDLE cycle at the earliest; there is no same-cycle turnaround from DONE.
- Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
- Both ready outputs are 0 in RUN and DONE. Requests are not queued; requesters hold valid and operands until ready.
- Operand changes after acceptance have no effect; operands are latched.
- Arithmetic: W-bit modular. Subtract computes a + ~b + 1. No overflow flag.

## Timing
- Reset values: req0_ready = req1_ready = 0 while rst = 1; res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, add_* = 0, k = 0, last-grant = 1.
- Reset mid-operation (RUN or DONE): the operation is discarded. The FSM is in IDLE on the next cycle, and no res_valid pulse occurs.
- Latency: handshake at cycle T, RUN from T+1 to T+NIBBLES, res_valid first high at T+NIBBLES+1 (cycle T+5 for NIBBLES = 4).
- Throughput: one operation per NIBBLES+2 cycles at best (IDLE + RUN + DONE).
- The adder slice path (add_a/add_b/add_cin to add_s/add_cout) is combinational within one clock period.
- Carry wraparound: the carry out of the top nibble goes only to res_cout, never to a following operation.
- res_valid with res_ready held low: the FSM stays in DONE indefinitely with outputs stable, and both ready outputs stay 0.

## Test plan
- req0 add, 0x1234 + 0x0FCD: res_valid at T+5, res_sum = 0x2201, res_cout = 0, res_id = 0. add_cin sequence over the four RUN cycles: 0,1,1,1.
- req1 subtract, 0x0005 - 0x0007: res_sum = 0xFFFE, res_cout = 0, res_id = 1. Then 0x0007 - 0x0005 gives 0x0002 with res_cout = 1.
- Wraparound, 0xFFFF + 0x0001: res_sum = 0x0000, res_cout = 1. add_s is captured correctly in every nibble.
- Both requesters valid continuously, out of reset: grants alternate 0,1,0,1, with results tagged res_id 0,1,0,1 and no starvation.
- res_ready held low for 10 cycles after res_valid: res_sum stays stable, both ready outputs stay 0, and the FSM leaves DONE in the cycle res_ready rises.
- rst asserted during the second RUN cycle: the next cycle is IDLE with all outputs at reset values, no result is produced, and the next request completes normally with the correct sum.
